deserializer: RTL and testbench

DESERIALIZER -- requirements
Module: deserializer

---
 rtl/deserializer.sv | 129 ++++++++++++
 tb/tb_deserializer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/deserializer.sv
// Serial-to-parallel frame assembler: collects one contiguous in_valid burst LSB-first,
// then holds the completed frame for a valid/ready consumer while dropping any new bits.
module deserializer #(
    parameter int MAX_BITS = 2401,
    parameter int LEN_W    = 33
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_data,
    input  logic                in_valid,
    output logic [MAX_BITS-1:0] frame_data,
    output logic [LEN_W-1:0]    frame_length,
    output logic                frame_overflow,
    output logic                frame_valid,
    input  logic                frame_ready,
    output logic                busy,
    output logic                dropped
);

    localparam int IDX_W = (MAX_BITS > 1) ? $clog2(MAX_BITS) : 1;
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BITS);

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        HOLD,
        DISCARD
    } state_t;

    state_t               state_q, state_d;
    logic [MAX_BITS-1:0]  buf_q, buf_d;
    logic [LEN_W-1:0]     count_q, count_d;
    logic                 ovf_q, ovf_d;
    logic [MAX_BITS-1:0]  frame_data_q, frame_data_d;
    logic [LEN_W-1:0]     frame_length_q, frame_length_d;
    logic                 frame_overflow_q, frame_overflow_d;
    logic                 dropped_q, dropped_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IDLE;
            buf_q            <= '0;
            count_q          <= '0;
            ovf_q            <= 1'b0;
            frame_data_q     <= '0;
            frame_length_q   <= '0;
            frame_overflow_q <= 1'b0;
            dropped_q        <= 1'b0;
        end else begin
            state_q          <= state_d;
            buf_q            <= buf_d;
            count_q          <= count_d;
            ovf_q            <= ovf_d;
            frame_data_q     <= frame_data_d;
            frame_length_q   <= frame_length_d;
            frame_overflow_q <= frame_overflow_d;
            dropped_q        <= dropped_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        buf_d            = buf_q;
        count_d          = count_q;
        ovf_d            = ovf_q;
        frame_data_d     = frame_data_q;
        frame_length_d   = frame_length_q;
        frame_overflow_d = frame_overflow_q;
        dropped_d        = dropped_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    buf_d    = '0;
                    buf_d[0] = in_data;
                    count_d  = LEN_W'(1);
                    ovf_d    = 1'b0;
                    state_d  = RECV;
                end
            end
            RECV: begin
                if (in_valid) begin
                    // Once full, further bits are discarded and only flagged.
                    if (count_q < MAX_LEN) begin
                        buf_d[count_q[IDX_W-1:0]] = in_data;
                        count_d = count_q + LEN_W'(1);
                    end else begin
                        ovf_d = 1'b1;
                    end
                end else begin
                    frame_data_d     = buf_q;
                    frame_length_d   = count_q;
                    frame_overflow_d = ovf_q;
                    state_d          = HOLD;
                end
            end
            HOLD: begin
                if (in_valid) begin
                    dropped_d = 1'b1;
                end
                // A burst starting on the accept cycle is already partial, so skip all of it.
                if (frame_ready) begin
                    if (in_valid) begin
                        state_d = DISCARD;
                    end else begin
                        state_d   = IDLE;
                        dropped_d = 1'b0;
                    end
                end
            end
            DISCARD: begin
                if (in_valid) begin
                    dropped_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign frame_data     = frame_data_q;
    assign frame_length   = frame_length_q;
    assign frame_overflow = frame_overflow_q;
    assign frame_valid    = (state_q == HOLD);
    assign busy           = (state_q != IDLE);
    assign dropped        = dropped_q;

endmodule

// File: tb/tb_deserializer.sv
// Directed bench for the deserializer: a cycle-by-cycle vector table plus
// hand-written sequences for discard, reset-mid-burst and overflow cases.
module tb_deserializer;

    localparam int MB = 2401;
    localparam int LW = 33;

    logic          clk;
    logic          rst;
    logic          inData;
    logic          inValid;
    logic [MB-1:0] frameData;
    logic [LW-1:0] frameLength;
    logic          frameOverflow;
    logic          frameValid;
    logic          frameReady;
    logic          busy;
    logic          dropped;

    int nChecks = 0;
    int nFail   = 0;

    typedef struct {
        logic       rst;
        logic       v;
        logic       d;
        logic       r;
        logic       eValid;
        logic       eBusy;
        logic       eDrop;
        logic       chk;
        int         eLen;
        logic [15:0] eData;
    } vec_t;

    vec_t vecs[$];

    deserializer #(.MAX_BITS(MB), .LEN_W(LW)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_data        (inData),
        .in_valid       (inValid),
        .frame_data     (frameData),
        .frame_length   (frameLength),
        .frame_overflow (frameOverflow),
        .frame_valid    (frameValid),
        .frame_ready    (frameReady),
        .busy           (busy),
        .dropped        (dropped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic rs, v, d, r, ev, eb, ed, c,
                                input int el, input logic [15:0] edat);
        vec_t x;
        x.rst = rs; x.v = v; x.d = d; x.r = r;
        x.eValid = ev; x.eBusy = eb; x.eDrop = ed; x.chk = c;
        x.eLen = el; x.eData = edat;
        return x;
    endfunction

    // Drive one cycle of inputs, then sample just after the edge that consumed them.
    task automatic applyStimulus(input logic rs, v, d, r);
        rst        = rs;
        inValid    = v;
        inData     = d;
        frameReady = r;
        @(posedge clk);
        #1;
    endtask

    task automatic checkBit(input string name, input logic act, input logic exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string name, input logic ev, eb, ed, c,
                               input int el, input logic [15:0] edat);
        checkBit({name, ".frame_valid"}, frameValid, ev);
        checkBit({name, ".busy"}, busy, eb);
        checkBit({name, ".dropped"}, dropped, ed);
        if (c) begin
            nChecks++;
            if (frameLength !== LW'(el)) begin
                nFail++;
                $display("[TB] FAIL %s.frame_length: got %0d expected %0d", name, frameLength, el);
            end
            nChecks++;
            if (frameData !== MB'(edat)) begin
                nFail++;
                $display("[TB] FAIL %s.frame_data: got low16 0x%h expected 0x%h (upper zero)",
                         name, frameData[15:0], edat);
            end
            checkBit({name, ".frame_overflow"}, frameOverflow, 1'b0);
        end
    endtask

    initial begin
        logic [9:0] burst10;
        logic allOnes;

        rst = 1'b1; inValid = 1'b0; inData = 1'b0; frameReady = 1'b0;

        // rst v d r | valid busy drop chk len data
        vecs.push_back(mk(1,0,0,0, 0,0,0,1, 0, 16'h0000));
        vecs.push_back(mk(0,1,1,0, 0,1,0,0, 0, 16'h0000));
        vecs.push_back(mk(0,1,0,0, 0,1,0,0, 0, 16'h0000));
        vecs.push_back(mk(0,1,1,0, 0,1,0,0, 0, 16'h0000));
        vecs.push_back(mk(0,1,0,0, 0,1,0,0, 0, 16'h0000));
        vecs.push_back(mk(0,1,0,0, 0,1,0,0, 0, 16'h0000));
        vecs.push_back(mk(0,1,1,0, 0,1,0,0, 0, 16'h0000));
        vecs.push_back(mk(0,1,0,0, 0,1,0,0, 0, 16'h0000));
        vecs.push_back(mk(0,1,1,0, 0,1,0,0, 0, 16'h0000));
        vecs.push_back(mk(0,0,0,0, 1,1,0,1, 8, 16'h00A5));
        vecs.push_back(mk(0,0,0,0, 1,1,0,1, 8, 16'h00A5));
        vecs.push_back(mk(0,1,1,0, 1,1,1,1, 8, 16'h00A5));
        vecs.push_back(mk(0,1,0,0, 1,1,1,1, 8, 16'h00A5));
        vecs.push_back(mk(0,1,1,0, 1,1,1,1, 8, 16'h00A5));
        vecs.push_back(mk(0,1,1,0, 1,1,1,1, 8, 16'h00A5));
        vecs.push_back(mk(0,0,0,0, 1,1,1,1, 8, 16'h00A5));
        vecs.push_back(mk(0,0,0,1, 0,0,0,0, 0, 16'h0000));
        vecs.push_back(mk(0,1,1,1, 0,1,0,0, 0, 16'h0000));
        vecs.push_back(mk(0,0,0,1, 1,1,0,1, 1, 16'h0001));
        vecs.push_back(mk(0,0,0,1, 0,0,0,0, 0, 16'h0000));
        vecs.push_back(mk(0,1,0,1, 0,1,0,0, 0, 16'h0000));
        vecs.push_back(mk(0,0,0,1, 1,1,0,1, 1, 16'h0000));
        vecs.push_back(mk(0,0,0,1, 0,0,0,0, 0, 16'h0000));

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].rst, vecs[i].v, vecs[i].d, vecs[i].r);
            checkOutput($sformatf("vec%0d", i), vecs[i].eValid, vecs[i].eBusy,
                        vecs[i].eDrop, vecs[i].chk, vecs[i].eLen, vecs[i].eData);
        end

        // Accept coinciding with a new burst's first bit: whole burst is discarded.
        applyStimulus(0,1,1,0);
        applyStimulus(0,1,1,0);
        applyStimulus(0,1,0,0);
        applyStimulus(0,0,0,0);
        checkOutput("disc.held", 1,1,0,1, 3, 16'h0003);
        applyStimulus(0,1,1,1);
        checkOutput("disc.enter", 0,1,1,0, 0, 16'h0000);
        applyStimulus(0,1,0,0);
        applyStimulus(0,1,1,1);
        checkOutput("disc.mid", 0,1,1,0, 0, 16'h0000);
        applyStimulus(0,0,0,0);
        checkOutput("disc.exit", 0,0,1,0, 0, 16'h0000);
        applyStimulus(0,1,0,0);
        applyStimulus(0,1,1,0);
        applyStimulus(0,0,0,0);
        checkOutput("disc.next", 1,1,1,1, 2, 16'h0002);
        applyStimulus(0,0,0,1);
        checkOutput("disc.xfer", 0,0,0,0, 0, 16'h0000);

        // Reset pulsed on bit 3 of a 10-bit burst; bits 4..9 form a new frame.
        burst10 = 10'b1001101111;
        for (int i = 0; i < 10; i++) begin
            applyStimulus((i == 3), 1'b1, burst10[i], 1'b0);
            if (i == 3) checkOutput("rstmid.reset", 0,0,0,1, 0, 16'h0000);
        end
        applyStimulus(0,0,0,0);
        checkOutput("rstmid.frame", 1,1,0,1, 6, 16'h0026);
        applyStimulus(0,1,1,0);
        checkOutput("rstmid.drop", 1,1,1,1, 6, 16'h0026);
        applyStimulus(1,0,0,1);
        checkOutput("rsthold", 0,0,0,1, 0, 16'h0000);

        // Overflow: MAX_BITS+5 ones saturate the length and raise the flag.
        for (int i = 0; i < MB + 5; i++) applyStimulus(0,1,1,0);
        applyStimulus(0,0,0,0);
        checkBit("ovf.frame_valid", frameValid, 1'b1);
        nChecks++;
        if (frameLength !== LW'(MB)) begin
            nFail++;
            $display("[TB] FAIL ovf.frame_length: got %0d expected %0d", frameLength, MB);
        end
        allOnes = &frameData;
        checkBit("ovf.frame_data_all_ones", allOnes, 1'b1);
        checkBit("ovf.frame_overflow", frameOverflow, 1'b1);
        applyStimulus(0,0,0,1);
        checkOutput("ovf.xfer", 0,0,0,0, 0, 16'h0000);
        applyStimulus(0,1,1,0);
        applyStimulus(0,0,0,0);
        checkOutput("ovf.after", 1,1,0,1, 1, 16'h0001);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
